// File: rtl/tx_wave_gen.sv
// Tx waveform generator: queues {value, keep} symbols and holds each level for keep*ptr clocks.
// Define TX_WAVE_SYM_CNT_EN to add the saturating symbol-load counter output sym_cnt.
module tx_wave_gen #(
  parameter int   PTR_WIDTH  = 11,
  parameter int   FIFO_AW    = 2,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst,
  input  logic                 Mod_enable,
  input  logic [PTR_WIDTH-1:0] cnt_point_ptr,
  input  logic                 sym_valid,
  output logic                 sym_ready,
  input  logic                 sym_value,
  input  logic [1:0]           sym_keep,
  output logic                 sym_err,
  output logic                 wave_out,
  output logic                 flag_edg_rise,
  output logic                 flag_edg_fall,
  output logic                 busy,
`ifdef TX_WAVE_SYM_CNT_EN
  output logic [15:0]          sym_cnt,
`endif
  output logic                 frame_done
);

  localparam int                 DEPTH   = 2 ** FIFO_AW;
  localparam int                 CW      = PTR_WIDTH + 2;
  localparam logic [FIFO_AW:0]   DEPTH_C = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0]   CNT_ONE = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE = FIFO_AW'(1);

  typedef enum logic {S_IDLE, S_HOLD} state_t;

  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic               r_wave;
  logic               r_rise;
  logic               r_fall;
  logic               r_done;
  logic               r_err;
  logic [2:0]         r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wrPtr;
  logic [FIFO_AW-1:0] r_rdPtr;
  logic [FIFO_AW:0]   r_count;

  logic          w_full;
  logic          w_empty;
  logic          w_xfer;
  logic          w_push;
  logic          w_bad;
  logic          w_holdDone;
  logic          w_pop;
  logic [2:0]    w_head;
  logic [CW-1:0] w_ptrEff;
  logic [CW-1:0] w_prod;
  logic [CW-1:0] w_loadVal;
  logic          w_waveNext;

  assign w_full     = (r_count == DEPTH_C);
  assign w_empty    = (r_count == '0);
  assign sym_ready  = Mod_enable & ~w_full;
  assign w_xfer     = sym_valid & sym_ready;
  assign w_push     = w_xfer & (sym_keep != 2'd0);
  assign w_bad      = w_xfer & (sym_keep == 2'd0);
  assign w_holdDone = (r_state == S_HOLD) && (r_cnt == '0);
  assign w_pop      = Mod_enable & ~w_empty & ((r_state == S_IDLE) | w_holdDone);
  assign w_head     = r_mem[r_rdPtr];

  // Hold length keep*ptr built from shifts and one add; keep is never 0 inside the FIFO.
  always_comb begin
    w_ptrEff = (cnt_point_ptr == '0) ? CW'(1) : CW'(cnt_point_ptr);
    case (w_head[1:0])
      2'd1:    w_prod = w_ptrEff;
      2'd2:    w_prod = w_ptrEff << 1;
      default: w_prod = w_ptrEff + (w_ptrEff << 1);
    endcase
    w_loadVal = w_prod - CW'(1);
  end

  always_comb begin
    if (!Mod_enable)     w_waveNext = IDLE_LEVEL;
    else if (w_pop)      w_waveNext = w_head[2];
    else if (w_holdDone) w_waveNext = IDLE_LEVEL;
    else                 w_waveNext = r_wave;
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wrPtr] <= {sym_value, sym_keep};
  end

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else if (!Mod_enable) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + PTR_ONE;
      if (w_pop)  r_rdPtr <= r_rdPtr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Edge flags compare the level about to be registered with the current one.
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_wave  <= IDLE_LEVEL;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_wave <= w_waveNext;
      r_rise <= ~r_wave & w_waveNext;
      r_fall <= r_wave & ~w_waveNext;
      r_err  <= w_bad;
      r_done <= 1'b0;
      if (!Mod_enable) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
      end else if (w_pop) begin
        r_state <= S_HOLD;
        r_cnt   <= w_loadVal;
      end else if (w_holdDone) begin
        r_state <= S_IDLE;
        r_done  <= 1'b1;
      end else if (r_state == S_HOLD) begin
        r_cnt <= r_cnt - CW'(1);
      end
    end
  end

`ifdef TX_WAVE_SYM_CNT_EN
  logic [15:0] r_symCnt;

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst)                                r_symCnt <= '0;
    else if (!Mod_enable)                   r_symCnt <= '0;
    else if (w_pop && r_symCnt != 16'hFFFF) r_symCnt <= r_symCnt + 16'd1;
  end

  assign sym_cnt = r_symCnt;
`endif

  assign wave_out      = r_wave;
  assign flag_edg_rise = r_rise;
  assign flag_edg_fall = r_fall;
  assign frame_done    = r_done;
  assign sym_err       = r_err;
  assign busy          = (r_state == S_HOLD) | ~w_empty;

endmodule

// File: tb/tb_tx_wave_gen.sv
// Scoreboard bench for tx_wave_gen: stimulus queues the expected pulse cycles, a monitor pops them.
module tb_tx_wave_gen;

  logic        clk_i = 1'b0;
  logic        rst;
  logic        Mod_enable;
  logic [10:0] cnt_point_ptr;
  logic        sym_valid;
  logic        sym_ready;
  logic        sym_value;
  logic [1:0]  sym_keep;
  logic        sym_err;
  logic        wave_out;
  logic        flag_edg_rise;
  logic        flag_edg_fall;
  logic        busy;
  logic        frame_done;
`ifdef TX_WAVE_SYM_CNT_EN
  logic [15:0] sym_cnt;
`endif

  int nChecks = 0;
  int nPass   = 0;
  int cyc     = 0;
  int expFall[$];
  int expRise[$];
  int expDone[$];
  int expErr[$];

  tx_wave_gen dut (
    .clk_i         (clk_i),
    .rst           (rst),
    .Mod_enable    (Mod_enable),
    .cnt_point_ptr (cnt_point_ptr),
    .sym_valid     (sym_valid),
    .sym_ready     (sym_ready),
    .sym_value     (sym_value),
    .sym_keep      (sym_keep),
    .sym_err       (sym_err),
    .wave_out      (wave_out),
    .flag_edg_rise (flag_edg_rise),
    .flag_edg_fall (flag_edg_fall),
    .busy          (busy),
`ifdef TX_WAVE_SYM_CNT_EN
    .sym_cnt       (sym_cnt),
`endif
    .frame_done    (frame_done)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    nChecks++;
    if (actual == expected) nPass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  // Offer one symbol and return just after the edge on which it was accepted.
  task automatic applyStimulus(input logic v, input logic [1:0] k);
    int waitCnt;
    sym_valid = 1'b1;
    sym_value = v;
    sym_keep  = k;
    waitCnt   = 0;
    while (!sym_ready && waitCnt < 100) begin
      waitCycles(1);
      waitCnt++;
    end
    if (waitCnt == 100) checkOutput("push ready timeout", int'(sym_ready), 1);
    waitCycles(1);
    sym_valid = 1'b0;
    sym_value = 1'b0;
    sym_keep  = 2'd0;
  endtask

  // Monitor: every pulse the DUT presents must match the head of its expectation queue.
  always @(negedge clk_i) begin
    if (!rst) begin
      if (flag_edg_fall) begin
        if (expFall.size() == 0) checkOutput("fall unexpected", cyc, -1);
        else checkOutput("fall cycle", cyc, expFall.pop_front());
        checkOutput("level after fall", int'(wave_out), 0);
      end
      if (flag_edg_rise) begin
        if (expRise.size() == 0) checkOutput("rise unexpected", cyc, -1);
        else checkOutput("rise cycle", cyc, expRise.pop_front());
        checkOutput("level after rise", int'(wave_out), 1);
      end
      if (frame_done) begin
        if (expDone.size() == 0) checkOutput("frame_done unexpected", cyc, -1);
        else checkOutput("frame_done cycle", cyc, expDone.pop_front());
      end
      if (sym_err) begin
        if (expErr.size() == 0) checkOutput("sym_err unexpected", cyc, -1);
        else checkOutput("sym_err cycle", cyc, expErr.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int c;
    rst           = 1'b1;
    Mod_enable    = 1'b0;
    cnt_point_ptr = 11'd0;
    sym_valid     = 1'b0;
    sym_value     = 1'b0;
    sym_keep      = 2'd0;
    #2;
    checkOutput("reset wave_out", int'(wave_out), 1);
    checkOutput("reset sym_ready", int'(sym_ready), 0);
    checkOutput("reset busy", int'(busy), 0);
    checkOutput("reset rise", int'(flag_edg_rise), 0);
    checkOutput("reset fall", int'(flag_edg_fall), 0);
    checkOutput("reset frame_done", int'(frame_done), 0);
    checkOutput("reset sym_err", int'(sym_err), 0);

    waitCycles(3);
    rst        = 1'b0;
    Mod_enable = 1'b1;
    waitCycles(4);
    checkOutput("idle wave_out", int'(wave_out), 1);
    checkOutput("idle busy", int'(busy), 0);
    checkOutput("idle sym_ready", int'(sym_ready), 1);

    // Two back-to-back symbols: 20 clocks low, 10 clocks high, then idle.
    cnt_point_ptr = 11'd10;
    c = cyc;
    expFall.push_back(c + 2);
    expRise.push_back(c + 22);
    expDone.push_back(c + 32);
    applyStimulus(1'b0, 2'd2);
    applyStimulus(1'b1, 2'd1);
    checkOutput("busy during frame", int'(busy), 1);
    waitCycles(35);
    checkOutput("busy after frame", int'(busy), 0);
    checkOutput("wave after frame", int'(wave_out), 1);

    // Five equal symbols fill the FIFO and run as one unbroken 60-clock low.
    cnt_point_ptr = 11'd4;
    c = cyc;
    expFall.push_back(c + 2);
    expRise.push_back(c + 62);
    expDone.push_back(c + 62);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 2'd3);
    checkOutput("fill ready low", int'(sym_ready), 0);
    checkOutput("fill cycle", cyc, c + 5);
    checkOutput("fill busy", int'(busy), 1);
    waitCycles(65);
    checkOutput("busy after long frame", int'(busy), 0);

    // keep=0 is consumed but discarded.
    c = cyc;
    expErr.push_back(c + 1);
    applyStimulus(1'b1, 2'd0);
    waitCycles(4);
    checkOutput("err wave_out", int'(wave_out), 1);
    checkOutput("err busy", int'(busy), 0);

    // Disable mid-hold with a second symbol queued: flush, rise, no frame_done.
    c = cyc;
    expFall.push_back(c + 2);
    expRise.push_back(c + 6);
    applyStimulus(1'b0, 2'd3);
    applyStimulus(1'b1, 2'd3);
    checkOutput("queued busy", int'(busy), 1);
    waitCycles(3);
    Mod_enable = 1'b0;
    #1;
    checkOutput("disabled sym_ready", int'(sym_ready), 0);
    waitCycles(1);
    Mod_enable = 1'b1;
    checkOutput("disable wave_out", int'(wave_out), 1);
    checkOutput("disable busy", int'(busy), 0);
    waitCycles(20);

    // Asynchronous reset in the middle of a held symbol.
    c = cyc;
    expFall.push_back(c + 2);
    applyStimulus(1'b0, 2'd3);
    waitCycles(3);
    rst = 1'b1;
    #1;
    checkOutput("async reset wave_out", int'(wave_out), 1);
    checkOutput("async reset busy", int'(busy), 0);
    waitCycles(1);
    rst = 1'b0;
    waitCycles(5);

    // ptr=0 behaves as 1: a single-clock low pulse.
    cnt_point_ptr = 11'd0;
    c = cyc;
    expFall.push_back(c + 2);
    expRise.push_back(c + 3);
    expDone.push_back(c + 3);
    applyStimulus(1'b0, 2'd1);
    waitCycles(6);
`ifdef TX_WAVE_SYM_CNT_EN
    checkOutput("sym_cnt after single symbol", int'(sym_cnt), 1);
`endif

    waitCycles(5);
    checkOutput("pending fall events", expFall.size(), 0);
    checkOutput("pending rise events", expRise.size(), 0);
    checkOutput("pending frame_done events", expDone.size(), 0);
    checkOutput("pending sym_err events", expErr.size(), 0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
